// File: rtl/tw_responder_if.sv
// Register-file side of the three-wire responder: decoded address/data,
// single-cycle strobes, status pulses and the read-response word.
interface tw_responder_if #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
);
  logic [ADDR_BITS-1:0] out_addr;
  logic [DATA_BITS-1:0] out_wr_data;
  logic                 out_wr_strobe;
  logic                 out_rd_strobe;
  logic                 out_busy;
  logic                 out_frame_err;
  logic [DATA_BITS-1:0] in_rd_data;

  // The responder drives the strobes; the register file answers reads.
  modport master (
    output out_addr, out_wr_data, out_wr_strobe, out_rd_strobe,
    output out_busy, out_frame_err,
    input  in_rd_data
  );

  modport slave (
    input  out_addr, out_wr_data, out_wr_strobe, out_rd_strobe,
    input  out_busy, out_frame_err,
    output in_rd_data
  );
endinterface

// File: rtl/tw_responder.sv
// Three-wire bus responder: oversamples clock/CS/data on in_clk, decodes
// read/write frames into register-file strobes and serialises read data.
module tw_responder #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
) (
  input  logic           in_clk,
  input  logic           in_reset,
  input  logic           in_tw_clock,
  input  logic           in_tw_cs_n,
  inout  wire            io_tw_data,
  tw_responder_if.master rf
);

  localparam int MAX_BITS = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
  localparam int CW       = $clog2(MAX_BITS + 1);

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BITS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] DATA_DONE = CW'(DATA_BITS);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CMD   = 3'd1;
  localparam logic [2:0] ADDR  = 3'd2;
  localparam logic [2:0] WDATA = 3'd3;
  localparam logic [2:0] TURN  = 3'd4;
  localparam logic [2:0] RDATA = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  // Bus synchronisers and registered edge pulses
  logic [1:0] clk_sync, cs_sync, dat_sync;
  logic       clk_d, cs_d, dat_d;
  logic       tw_rise, tw_fall, cs_rise, cs_fall;

  // Frame decoder state
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic                 rw;
  logic [ADDR_BITS-1:0] addr_sh;
  logic [DATA_BITS-1:0] data_sh;
  logic                 rd_load;
  logic                 tw_oe;
  logic                 tw_out;

  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wr_data_q;
  logic                 wr_strobe_q;
  logic                 rd_strobe_q;
  logic                 frame_err_q;

  logic [ADDR_BITS-1:0] addr_next;
  logic [DATA_BITS-1:0] data_next;

  assign addr_next = {addr_sh[ADDR_BITS-2:0], dat_d};
  assign data_next = {data_sh[DATA_BITS-2:0], dat_d};

  // NOTE: state elements use non-blocking assignments so every register in
  // the chain samples the pre-edge value; blocking here would collapse stages.
  // NOTE: CS is reset to the asserted level so a CS already low at reset
  // release never looks like a falling edge; it must rise and fall again.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      clk_sync <= '0;
      cs_sync  <= '0;
      dat_sync <= '0;
      clk_d    <= 1'b0;
      cs_d     <= 1'b0;
      dat_d    <= 1'b0;
      tw_rise  <= 1'b0;
      tw_fall  <= 1'b0;
      cs_rise  <= 1'b0;
      cs_fall  <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], in_tw_clock};
      cs_sync  <= {cs_sync[0], in_tw_cs_n};
      dat_sync <= {dat_sync[0], io_tw_data};
      clk_d    <= clk_sync[1];
      cs_d     <= cs_sync[1];
      dat_d    <= dat_sync[1];
      tw_rise  <= clk_sync[1] & ~clk_d;
      tw_fall  <= ~clk_sync[1] & clk_d;
      cs_rise  <= cs_sync[1] & ~cs_d;
      cs_fall  <= ~cs_sync[1] & cs_d;
    end
  end

  // NOTE: pulse outputs are defaulted low at the top of the clocked branch so
  // each assertion below lasts exactly one cycle.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rw          <= 1'b0;
      addr_sh     <= '0;
      data_sh     <= '0;
      rd_load     <= 1'b0;
      tw_oe       <= 1'b0;
      tw_out      <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      rd_load     <= rd_strobe_q;

      // CS rising mid-frame wins over any coincident bus clock edge.
      if (cs_rise && state != IDLE && state != DONE) begin
        state       <= IDLE;
        cnt         <= '0;
        tw_oe       <= 1'b0;
        frame_err_q <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state <= CMD;
              cnt   <= '0;
            end
          end
          CMD: begin
            if (tw_rise) begin
              rw    <= dat_d;
              state <= ADDR;
              cnt   <= '0;
            end
          end
          ADDR: begin
            if (tw_rise) begin
              addr_sh <= addr_next;
              if (cnt == ADDR_LAST) begin
                addr_q <= addr_next;
                cnt    <= '0;
                if (rw) begin
                  state <= WDATA;
                end else begin
                  state       <= TURN;
                  rd_strobe_q <= 1'b1;
                end
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          WDATA: begin
            if (tw_rise) begin
              data_sh <= data_next;
              if (cnt == DATA_LAST) begin
                wr_data_q   <= data_next;
                wr_strobe_q <= 1'b1;
                state       <= DONE;
                cnt         <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          TURN: begin
            // cnt flags that the turnaround rising edge has gone by.
            if (rd_load) data_sh <= rf.in_rd_data;
            if (tw_rise) begin
              cnt <= CW'(1);
            end else if (tw_fall && cnt != '0) begin
              tw_oe   <= 1'b1;
              tw_out  <= data_sh[DATA_BITS-1];
              data_sh <= data_sh << 1;
              state   <= RDATA;
              cnt     <= '0;
            end
          end
          RDATA: begin
            if (tw_rise) begin
              cnt <= cnt + CW'(1);
            end else if (tw_fall) begin
              if (cnt == DATA_DONE) begin
                tw_oe <= 1'b0;
                state <= DONE;
                cnt   <= '0;
              end else begin
                tw_out  <= data_sh[DATA_BITS-1];
                data_sh <= data_sh << 1;
              end
            end
          end
          DONE: begin
            if (cs_rise) begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            tw_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_tw_data       = tw_oe ? tw_out : 1'bz;
  assign rf.out_addr      = addr_q;
  assign rf.out_wr_data   = wr_data_q;
  assign rf.out_wr_strobe = wr_strobe_q;
  assign rf.out_rd_strobe = rd_strobe_q;
  assign rf.out_frame_err = frame_err_q;
  assign rf.out_busy      = (state != IDLE);

endmodule

// File: doc/tw_responder.md
# tw_responder

Synthesizable slave (responder) end of the three-wire bus: clock, chip-select, bidirectional data. The `top` FPGA bridge drives this bus as master. The block oversamples the bus on its own system clock and decodes read/write frames. It presents address and data to a local register file through single-cycle strobes. For read frames it serialises the register file's response back onto the shared data line.

## Interface
- `ADDR_BITS`, default 10: address field width.
- `DATA_BITS`, default 32: data field width.
- `in_clk` in 1: system clock; all logic on rising edge.
- `in_reset` in 1: synchronous, active-high reset.
- `in_tw_clock` in 1: bus clock from master; asynchronous to `in_clk`.
- `in_tw_cs_n` in 1: bus chip-select, active low; asynchronous.
- `io_tw_data` inout 1: bus data; high-Z unless the responder is driving.
- `out_addr` out ADDR_BITS: address of the last decoded frame.
- `out_wr_data` out DATA_BITS: data of the last write frame.
- `out_wr_strobe` out 1: one-cycle pulse when a write frame completes.
- `out_rd_strobe` out 1: one-cycle pulse when a read address completes.
- `in_rd_data` in DATA_BITS: read response; must be valid on the cycle after `out_rd_strobe`.
- `out_busy` out 1: high while a frame is in progress (any state except IDLE).
- `out_frame_err` out 1: one-cycle pulse when a frame is aborted.

## Operation
- Frame format, MSB first:
  - Bit 0 is R/W: 1 = write, 0 = read.
  - Then ADDR_BITS address bits.
  - Write: then DATA_BITS data bits from the master.
  - Read: then one turnaround bit, then DATA_BITS bits driven by the responder.
- Master changes data on falling `tw_clock` and samples on rising. The responder samples on rising and drives on falling.
- Synchronisation:
  - `in_tw_clock`, `in_tw_cs_n` and the `io_tw_data` input each pass through a 2-FF synchronizer.
  - Edges are detected from the synchronized stage against a third register.
- States: IDLE, CMD, ADDR, WDATA, TURN, RDATA, DONE.
  - IDLE -> CMD on synchronized CS falling edge. CS already low at reset release is ignored until it goes high.
  - CMD: first rising edge latches R/W -> ADDR.
  - ADDR: bit counter counts ADDR_BITS rising edges. After the last one, `out_addr` is updated.
    - Write: -> WDATA.
    - Read: -> TURN, with `out_rd_strobe` pulsed.
  - WDATA: after DATA_BITS rising edges, `out_wr_data` is updated, `out_wr_strobe` is pulsed -> DONE.
  - TURN: the cycle after `out_rd_strobe`, `in_rd_data` is loaded into the shift register.
    - The turnaround rising edge is ignored.
    - On the following falling edge, the driver is enabled with the MSB -> RDATA.
  - RDATA: each subsequent falling edge shifts out the next bit. The falling edge after the last bit's rising edge releases the line -> DONE.
  - DONE: all further bus clocks are ignored. CS rising -> IDLE.
- Abort:
  - CS deasserted in any state other than IDLE/DONE -> release the line, pulse `out_frame_err`, go to IDLE.
  - No write/read strobe is issued for an aborted frame.
  - `out_addr` and `out_wr_data` keep their previous values.
- Counter is $clog2(max(ADDR_BITS,DATA_BITS)+1) bits wide and cleared on every state entry.

## Timing
- Reset values:
  - `out_addr` = 0, `out_wr_data` = 0.
  - `out_wr_strobe`, `out_rd_strobe`, `out_busy`, `out_frame_err` = 0.
  - `io_tw_data` = Z.
  - State = IDLE.
- Reset mid-frame: line released on the cycle after reset is sampled; no strobes issued.
- Bus edge to internal event latency: 3 `in_clk` cycles (2 sync + 1 detect).
- Falling edge to pin drive: 4 `in_clk` cycles.
- Requirement: each `tw_clock` high and low phase lasts at least 6 `in_clk` cycles.
- Strobes are exactly one cycle long; never both in one cycle.
- `out_addr` is valid on the strobe cycle and held until the next completed address.
- `out_wr_data` is valid on the `out_wr_strobe` cycle and held until the next completed write.
- Simultaneous CS rise and last rising edge: CS wins and the frame is aborted.

## Test plan
- Write with ADDR_BITS=10, DATA_BITS=32: R/W=1, addr 0x1BB, data 0xCCDDEEFF.
  -> one `out_wr_strobe`; `out_addr`=0x1BB; `out_wr_data`=0xCCDDEEFF; no rd strobe.
- Read: R/W=0, addr 0x3BB; bench returns 0xAABBCCDD the cycle after `out_rd_strobe`.
  -> master samples 0xAABBCCDD MSB first; line is Z during turnaround and after the last bit.
- Abort after 5 address bits (CS high).
  -> `out_frame_err` pulse; no strobes; `out_addr` unchanged; next full write decodes correctly.
- Write frame followed by 3 extra `tw_clock` pulses before CS high.
  -> exactly one `out_wr_strobe`; `io_tw_data` never driven.
- Reset asserted mid-RDATA at bit 12.
  -> line Z next cycle; all outputs at reset values; subsequent read of addr 0x001 returns `in_rd_data` correctly.
- Back-to-back write then read with CS high for one `tw_clock` period between frames.
  -> both frames decode; `out_busy` low during the gap.
